// File: rtl/sat_pkg.sv
// Shared SAT-solver definitions: variable-count limits and the implication entry layout.
package sat_pkg;

  localparam int MAX_VAR_COUNT = 512;
  localparam int VAR_IDX_W     = 9;

  typedef struct packed {
    logic [VAR_IDX_W-1:0] var_idx;
    logic                 val;
  } imply_entry_t;

  function automatic imply_entry_t make_entry(input logic [VAR_IDX_W-1:0] idx, input logic v);
    imply_entry_t e;
    e.var_idx = idx;
    e.val     = v;
    return e;
  endfunction

endpackage

// File: rtl/imply_stack_mem.sv
// Implication storage: one synchronous write port, one asynchronous read port, no reset.
module imply_stack_mem
  import sat_pkg::*;
#(
  parameter int DEPTH  = MAX_VAR_COUNT,
  parameter int ADDR_W = VAR_IDX_W,
  parameter int DATA_W = VAR_IDX_W + 1
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write port; contents are intentionally left unreset since count defines validity.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/imply_stack.sv
// LIFO of implied variable assignments with 1-cycle registered pop, flush and sticky error flags.
module imply_stack
  import sat_pkg::*;
#(
  parameter int DEPTH = MAX_VAR_COUNT,
  parameter int IDX_W = VAR_IDX_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_en,
  input  logic [IDX_W-1:0] push_var_idx,
  input  logic             push_val,
  input  logic             pop_en,
  input  logic             flush,
  output logic             pop_valid,
  output logic [IDX_W-1:0] pop_var_idx,
  output logic             pop_val,
  output logic             empty,
  output logic             full,
  output logic [IDX_W:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   ZERO_C  = {(IDX_W+1){1'b0}};
  localparam logic [IDX_W:0]   ONE_C   = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] ONE_A_C = {{(IDX_W-1){1'b0}}, 1'b1};

  logic [IDX_W:0]   count_r;
  logic [IDX_W:0]   count_nxt_s;
  logic             pop_valid_r;
  logic [IDX_W-1:0] pop_var_idx_r;
  logic             pop_val_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             pop_ok_s;
  logic             wr_en_s;
  logic             ovf_set_s;
  logic             unf_set_s;
  logic [IDX_W-1:0] wr_addr_s;
  logic [IDX_W-1:0] top_addr_s;
  logic [IDX_W:0]   wr_data_s;
  logic [IDX_W:0]   rd_data_s;

  assign empty_s    = (count_r == ZERO_C);
  assign full_s     = (count_r == DEPTH_C);
  // Low bits of count wrap to DEPTH-1 when full, which is exactly the top slot.
  assign top_addr_s = count_r[IDX_W-1:0] - ONE_A_C;
  assign wr_data_s  = {push_var_idx, push_val};

  imply_stack_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (IDX_W),
    .DATA_W (IDX_W + 1)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_data_s),
    .rd_addr (top_addr_s),
    .rd_data (rd_data_s)
  );

  // Next-count, write-port and error-set decode; flush overrides push and pop.
  always_comb begin
    push_s      = push_en & ~flush;
    pop_s       = pop_en & ~flush;
    pop_ok_s    = pop_s & ~empty_s;
    wr_en_s     = 1'b0;
    wr_addr_s   = count_r[IDX_W-1:0];
    count_nxt_s = count_r;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    if (flush) begin
      count_nxt_s = ZERO_C;
    end else if (pop_ok_s) begin
      if (push_s) begin
        wr_en_s   = 1'b1;
        wr_addr_s = top_addr_s;
      end else begin
        count_nxt_s = count_r - ONE_C;
      end
    end else begin
      unf_set_s = pop_s;
      if (push_s && !full_s) begin
        wr_en_s     = 1'b1;
        count_nxt_s = count_r + ONE_C;
      end else if (push_s) begin
        ovf_set_s = 1'b1;
      end else begin
        ovf_set_s = 1'b0;
      end
    end
  end

  // Count, pop output registers and sticky flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r       <= ZERO_C;
      pop_valid_r   <= 1'b0;
      pop_var_idx_r <= {IDX_W{1'b0}};
      pop_val_r     <= 1'b0;
      overflow_r    <= 1'b0;
      underflow_r   <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      pop_valid_r <= pop_ok_s;
      if (pop_ok_s) begin
        pop_var_idx_r <= rd_data_s[IDX_W:1];
        pop_val_r     <= rd_data_s[0];
      end
      if (flush) begin
        overflow_r  <= 1'b0;
        underflow_r <= 1'b0;
      end else begin
        overflow_r  <= overflow_r | ovf_set_s;
        underflow_r <= underflow_r | unf_set_s;
      end
    end
  end

  assign pop_valid   = pop_valid_r;
  assign pop_var_idx = pop_var_idx_r;
  assign pop_val     = pop_val_r;
  assign count       = count_r;
  assign empty       = empty_s;
  assign full        = full_s;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

endmodule

// File: tb/tb_imply_stack.sv
// Directed plus random stimulus for imply_stack against a queue-based LIFO reference model.
module tb_imply_stack;
  import sat_pkg::*;

  localparam int DEPTH = MAX_VAR_COUNT;
  localparam int IDX_W = VAR_IDX_W;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             push_en = 1'b0;
  logic [IDX_W-1:0] push_var_idx = '0;
  logic             push_val = 1'b0;
  logic             pop_en = 1'b0;
  logic             flush = 1'b0;
  logic             pop_valid;
  logic [IDX_W-1:0] pop_var_idx;
  logic             pop_val;
  logic             empty;
  logic             full;
  logic [IDX_W:0]   count;
  logic             overflow;
  logic             underflow;

  int checks = 0;
  int errors = 0;

  imply_entry_t m_q[$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;
  logic         m_pv = 1'b0;
  imply_entry_t m_pop = '0;

  imply_stack #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset_n(reset_n), .push_en(push_en), .push_var_idx(push_var_idx),
    .push_val(push_val), .pop_en(pop_en), .flush(flush), .pop_valid(pop_valid),
    .pop_var_idx(pop_var_idx), .pop_val(pop_val), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_pv  = 1'b0;
    m_pop = '0;
  endtask

  task automatic model_step(input logic p, input logic [IDX_W-1:0] idx, input logic v,
                            input logic po, input logic f);
    m_pv = 1'b0;
    if (f) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (po) begin
        if (m_q.size() > 0) begin
          m_pop = m_q.pop_back();
          m_pv  = 1'b1;
        end else begin
          m_unf = 1'b1;
        end
      end
      if (p) begin
        if (m_q.size() < DEPTH) m_q.push_back(make_entry(idx, v));
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(m_q.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    check({tag, ".pop_valid"}, 32'(pop_valid), 32'(m_pv));
    if (m_pv) begin
      check({tag, ".pop_var_idx"}, 32'(pop_var_idx), 32'(m_pop.var_idx));
      check({tag, ".pop_val"}, 32'(pop_val), 32'(m_pop.val));
    end
  endtask

  task automatic step(input string tag, input logic p, input logic [IDX_W-1:0] idx,
                      input logic v, input logic po, input logic f);
    push_en = p; push_var_idx = idx; push_val = v; pop_en = po; flush = f;
    @(posedge clock);
    #1;
    model_step(p, idx, v, po, f);
    push_en = 1'b0; pop_en = 1'b0; flush = 1'b0;
    compare_all(tag);
  endtask

  initial begin
    int pct_push;
    int pct_pop;
    #12;
    compare_all("reset");
    check("reset.pop_var_idx", 32'(pop_var_idx), 32'd0);
    check("reset.pop_val", 32'(pop_val), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic LIFO ordering
    step("p5", 1'b1, 9'd5, 1'b1, 1'b0, 1'b0);
    step("p17", 1'b1, 9'd17, 1'b0, 1'b0, 1'b0);
    step("p300", 1'b1, 9'd300, 1'b1, 1'b0, 1'b0);
    step("pop1", 1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    check("pop1.idx", 32'(pop_var_idx), 32'd300);
    step("pop2", 1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    check("pop2.idx", 32'(pop_var_idx), 32'd17);
    step("pop3", 1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    check("pop3.idx", 32'(pop_var_idx), 32'd5);
    step("idle", 1'b0, 9'd0, 1'b0, 1'b0, 1'b0);
    check("idle.empty", 32'(empty), 32'd1);

    // Fill to capacity, then one more
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 9'(i), i[0], 1'b0, 1'b0);
    check("fill.full", 32'(full), 32'd1);
    step("ovf", 1'b1, 9'd0, 1'b1, 1'b0, 1'b0);
    check("ovf.flag", 32'(overflow), 32'd1);
    check("ovf.count", 32'(count), 32'd512);
    step("ovf.pop", 1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    check("ovf.top", 32'(pop_var_idx), 32'd511);
    step("full.pushpop0", 1'b1, 9'd77, 1'b0, 1'b0, 1'b0);
    step("full.pushpop", 1'b1, 9'd88, 1'b1, 1'b1, 1'b0);
    check("full.pushpop.idx", 32'(pop_var_idx), 32'd77);
    step("flush1", 1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
    check("flush1.ovf", 32'(overflow), 32'd0);

    // Simultaneous push and pop with count=2
    step("s1", 1'b1, 9'd3, 1'b1, 1'b0, 1'b0);
    step("s2", 1'b1, 9'd9, 1'b0, 1'b0, 1'b0);
    step("swap", 1'b1, 9'd42, 1'b1, 1'b1, 1'b0);
    check("swap.idx", 32'(pop_var_idx), 32'd9);
    check("swap.count", 32'(count), 32'd2);
    step("swap.pop", 1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    check("swap.pop.idx", 32'(pop_var_idx), 32'd42);
    step("drain", 1'b0, 9'd0, 1'b0, 1'b1, 1'b0);

    // Underflow on empty, with and without a concurrent push
    step("unf", 1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    check("unf.flag", 32'(underflow), 32'd1);
    step("unf.flush", 1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
    step("unf.pushpop", 1'b1, 9'd11, 1'b1, 1'b1, 1'b0);
    check("unf.pushpop.count", 32'(count), 32'd1);
    step("unf.flush2", 1'b0, 9'd0, 1'b0, 1'b0, 1'b1);

    // Flush beats a same-cycle push
    for (int i = 0; i < 10; i++) step("f10", 1'b1, 9'(i + 100), 1'b0, 1'b0, 1'b0);
    step("flushpush", 1'b1, 9'd7, 1'b1, 1'b0, 1'b1);
    check("flushpush.count", 32'(count), 32'd0);
    step("flushpush.pop", 1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    check("flushpush.unf", 32'(underflow), 32'd1);
    step("flush2", 1'b0, 9'd0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 5; i++) step("r5", 1'b1, 9'(i + 200), 1'b1, 1'b0, 1'b0);
    step("rpop", 1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    check("rpop.count", 32'(count), 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    check("async_rst.idx", 32'(pop_var_idx), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step("rst.push", 1'b1, 9'd1, 1'b1, 1'b0, 1'b0);
    step("rst.pop", 1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    check("rst.pop.idx", 32'(pop_var_idx), 32'd1);
    check("rst.pop.val", 32'(pop_val), 32'd1);

    // Randomized phases with shifting push/pop bias
    for (int ph = 0; ph < 4; ph++) begin
      pct_push = (ph == 1) ? 90 : ((ph == 2) ? 20 : 55);
      pct_pop  = (ph == 1) ? 15 : ((ph == 2) ? 80 : 45);
      for (int i = 0; i < 700; i++) begin
        step("rand", ($urandom_range(0, 99) < pct_push), 9'($urandom), 1'($urandom),
             ($urandom_range(0, 99) < pct_pop), ($urandom_range(0, 199) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imply_stack.md
IMPLY_STACK -- requirements
Module: imply_stack

Interface
REQ-001 Parameter DEPTH, default 512: number of entries; equals the maximum variable count.
REQ-002 Parameter IDX_W, default 9: width of a variable index.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 push_en  input  1  push request, driven by the conflict detector's push-enable output.
REQ-006 push_var_idx  input  IDX_W  implied variable index to store.
REQ-007 push_val  input  1  implied value to store.
REQ-008 pop_en  input  1  solver request to remove the top entry.
REQ-009 flush  input  1  solver request to discard all entries, used on conflict or restart.
REQ-010 pop_valid  output  1  registered; high for one cycle when pop data is valid.
REQ-011 pop_var_idx  output  IDX_W  registered variable index of the popped entry.
REQ-012 pop_val  output  1  registered value of the popped entry.
REQ-013 empty  output  1  high when count == 0.
REQ-014 full  output  1  high when count == DEPTH.
REQ-015 count  output  IDX_W+1  current number of stored entries.
REQ-016 overflow  output  1  sticky error flag for a push while full.
REQ-017 underflow  output  1  sticky error flag for a pop while empty.

Function
REQ-018 Storage SHALL be LIFO: each pop returns the most recently pushed entry that has not yet been popped.
REQ-019 A push SHALL write {push_var_idx, push_val} at index count, and count SHALL increment on the same edge.
REQ-020 A pop SHALL read the entry at index count-1 into pop_var_idx/pop_val, set pop_valid the next cycle, and decrement count on the same edge.
REQ-021 Pop latency SHALL be exactly 1 cycle; pop_valid SHALL be low in every cycle not following an accepted pop.
REQ-022 Simultaneous push and pop with count>0 SHALL pop the old top (output it) and write the new entry in its slot; count SHALL stay unchanged.
REQ-023 Simultaneous push and pop with count==0 SHALL accept the push only, leave pop_valid low, and set underflow.
REQ-024 A push while full and not popping SHALL be dropped, leave count at DEPTH, and set overflow.
REQ-025 A simultaneous push and pop while full SHALL follow REQ-022 (no overflow).
REQ-026 A pop while empty SHALL leave count at 0, leave pop_valid low, and set underflow.
REQ-027 flush SHALL have priority over push and pop: count goes to 0, pop_valid is low next cycle, and any same-cycle push or pop is discarded.
REQ-028 flush SHALL clear overflow and underflow.
REQ-029 After a flush or reset, stored entry contents are don't-care; only count defines validity.
REQ-030 count arithmetic SHALL use IDX_W+1 bits so that DEPTH=512 is representable; no wrap-around is permitted.
REQ-031 empty and full SHALL be combinational functions of the registered count.

Reset
REQ-032 Asserting reset_n low SHALL immediately force count=0, pop_valid=0, pop_var_idx=0, pop_val=0, overflow=0 and underflow=0, independent of clock.
REQ-033 Storage array contents SHALL NOT be reset.
REQ-034 Deasserting reset mid-operation SHALL leave the stack empty, and the first edge after deassertion SHALL accept a push normally.

Structure
REQ-035 A shared package sat_pkg SHALL hold:
- MAX_VAR_COUNT (512)
- VAR_IDX_W (9)
- packed typedef imply_entry_t {var_idx, val}
REQ-036 The storage array SHALL be a sub-module imply_stack_mem with 1 write port and 1 read port, addressed by the control logic; the control logic holds count, the flags and the output registers.

Verification
REQ-037 Reset, then push (5,1), (17,0), (300,1), then pop x3 -> pop outputs (300,1), (17,0), (5,1) one cycle after each pop_en; count ends 0; empty=1.
REQ-038 Push 512 distinct entries, then a 513th -> full=1, count=512, overflow=1; the top entry is still entry #512.
REQ-039 With count=2, top (9,0), push (42,1) and pop together -> pop outputs (9,0); count=2; next pop returns (42,1).
REQ-040 Pop on an empty stack -> pop_valid stays 0, count=0, underflow=1; then flush -> underflow=0.
REQ-041 With count=10, assert flush together with push (7,1) -> count=0 and empty=1 next cycle; a following pop sets underflow.
REQ-042 Drop reset_n between clock edges while count=4 and pop_valid=1 -> count=0 and pop_valid=0 immediately; after release, push (1,1) then pop returns (1,1).
